fpu_muldiv_iter: RTL
====================

// Module: fpu_muldiv_iter
// PURPOSE
//  Iterative multi-cycle IEEE-754 multiply/divide unit, parametrised in exponent/fraction width
//  (single, double or custom formats) with valid/ready handshakes on both sides and exception flags.
//  Sits beside the combinational add/sub path in the FP execute stage.
//  Holds one operation in flight; the pipeline stalls on in_ready/out_valid.
// PARAMETERS
//  EXP_W   8   exponent field width (11 for double)
//  FRAC_W  23  stored fraction width (52 for double); W = 1+EXP_W+FRAC_W, MW = FRAC_W+1
// PORTS
//  clk        in   1  clock, rising edge
//  reset_n    in   1  asynchronous active-low reset
//  flush      in   1  synchronous abort of any in-flight op
//  in_valid   in   1  operands/op valid
//  in_ready   out  1  unit can accept (state IDLE)
//  op         in   1  0 = a*b, 1 = a/b
//  a, b       in   W  IEEE operands
//  out_valid  out  1  result valid; held until accepted
//  out_ready  in   1  consumer accepts result
//  result     out  W  IEEE result
//  flags      out  4  {invalid, div_by_zero, overflow, underflow}, valid with result
// BEHAVIOUR
//  - Reset (async, reset_n=0): state IDLE, in_ready=1, out_valid=0, result=0, flags=0, datapath regs 0.
//  - Single clock domain; all outputs registered.
//  - FSM IDLE -> UNPACK -> ITER -> NORM -> DONE -> IDLE.
//  - IDLE: in_valid && in_ready at an edge latches a, b, op; next state UNPACK.
//  - UNPACK (1 cycle): extract sign = a.s ^ b.s, exponents and mantissas with hidden bit.
//    exp==0 is treated as zero (denormals flushed).
//    Special cases resolved here: result/flags loaded, jump straight to DONE.
//  - Special-case table (exp all-ones, frac!=0 is NaN):
//    - any NaN -> canonical qNaN {0, 1..1, 1, 0..0}
//    - 0*inf, 0/0, inf/inf -> qNaN, invalid
//    - x/0 (x finite nonzero) -> signed inf, div_by_zero
//    - inf*x, inf/x, inf/0 -> signed inf, no flag
//    - 0*x, 0/x, x/inf -> signed zero
//  - Exponent arithmetic in EXP_W+2-bit signed: mul ea+eb-bias; div ea-eb+bias.
//  - ITER: exactly MW+1 cycles, counter counts down from MW to 0.
//    - mul: radix-2 shift-add of ma by mb bits, 2*MW-bit product.
//    - div: restoring division of ma by mb, one quotient bit per cycle, MW+1 quotient bits.
//  - NORM (1 cycle): normalise by at most one position (product in [1,4), quotient in (0.5,2)),
//    adjust exponent, truncate (round toward zero). Then:
//    - exp >= all-ones -> signed inf, overflow
//    - exp <= 0 -> signed zero, underflow
//    - otherwise pack the result.
//  - Latency from the accepting edge to out_valid rising:
//    - normal path: FRAC_W+5 edges (single 28, double 57)
//    - special path: 2 edges
//  - DONE: out_valid=1, result and flags stable. Leave to IDLE on the edge where out_ready=1;
//    in_ready rises the cycle after. Output is never overwritten while out_valid=1
//    (out_ready low holds indefinitely).
//  - No new operation is accepted in DONE, even when out_ready=1 on the same edge.
//  - flush=1 at an edge: any state -> IDLE, out_valid=0. flush wins over in_valid and out_ready.
//  - reset_n low mid-operation: immediate return to reset values; no result is produced.
// TESTING
//  1 Single: a=3FC00000 (1.5), b=40000000, op=0 -> result 40400000, flags 0, out_valid at edge 28.
//  2 Single: a=3F800000, b=40400000, op=1 -> result 3EAAAAAA (truncated 1/3), flags 0.
//  3 Specials: 3F800000/00000000 -> 7F800000, div_by_zero;
//    00000000*7F800000 -> 7FC00000, invalid; each at latency 2.
//  4 Range: 7F000000*7F000000 -> 7F800000, overflow; 00800000*00800000 -> 00000000, underflow.
//  5 Handshake: hold out_ready=0 for 10 cycles -> result/out_valid stable, in_ready=0;
//    then out_ready=1 -> in_ready rises next cycle.
//  6 Abort: flush mid-ITER, and reset_n pulse mid-ITER -> back to IDLE with out_valid=0;
//    the next op completes correctly. Repeat test 1 with EXP_W=11, FRAC_W=52: 3FF8..0*4000..0 -> 4008..0.

Source files
------------

// File: rtl/fpu_muldiv_iter.sv
// Iterative IEEE-754 multiply/divide unit.
// Holds one operation in flight. Mantissas are multiplied by radix-2 shift-add or divided
// by restoring division, one bit per cycle. Denormal inputs are flushed to zero and results
// are truncated (round toward zero).
//
// Ports:
//   clk        rising-edge clock
//   reset_n    asynchronous active-low reset
//   flush      synchronous abort of any in-flight operation
//   in_valid   operands/op valid
//   in_ready   unit idle and able to accept
//   op         0 = a*b, 1 = a/b
//   a, b       IEEE operands
//   out_valid  result valid, held until out_ready
//   out_ready  consumer accepts the result
//   result     IEEE result
//   flags      {invalid, div_by_zero, overflow, underflow}, valid with result
module fpu_muldiv_iter #(
   parameter int unsigned EXP_W  = 8,
   parameter int unsigned FRAC_W = 23
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  flush,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic                  op,
   input  logic [EXP_W+FRAC_W:0] a,
   input  logic [EXP_W+FRAC_W:0] b,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [EXP_W+FRAC_W:0] result,
   output logic [3:0]            flags
);

   localparam int unsigned W  = 1 + EXP_W + FRAC_W;
   localparam int unsigned MW = FRAC_W + 1;
   localparam int unsigned EW = EXP_W + 2;
   localparam int unsigned CW = $clog2(MW + 1);

   localparam logic signed [EW-1:0] BIAS    = EW'((1 << (EXP_W - 1)) - 1);
   localparam logic signed [EW-1:0] EXP_MAX = EW'((1 << EXP_W) - 1);
   localparam logic signed [EW-1:0] ONE     = EW'(1);

   localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(FRAC_W-1){1'b0}}};

   typedef enum logic [2:0] {StIdle, StUnpack, StIter, StNorm, StDone} state_e;

   state_e               state_q, state_d;
   logic                 op_q, op_d;
   logic [W-1:0]         a_q, a_d, b_q, b_d;
   logic                 sign_q, sign_d;
   logic signed [EW-1:0] exp_q, exp_d;
   logic [MW-1:0]        ma_q, ma_d, mb_q, mb_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [2*MW-1:0]      prod_q, prod_d;
   logic [MW:0]          rem_q, rem_d;
   logic [MW:0]          quo_q, quo_d;
   logic [W-1:0]         result_q, result_d;
   logic [3:0]           flags_q, flags_d;
   logic                 out_valid_q, out_valid_d;
   logic                 in_ready_q, in_ready_d;

   // Operand fields
   logic [EXP_W-1:0]  ea, eb;
   logic [FRAC_W-1:0] fa, fb;
   logic              a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
   logic              res_sign;

   assign ea       = a_q[W-2 -: EXP_W];
   assign eb       = b_q[W-2 -: EXP_W];
   assign fa       = a_q[FRAC_W-1:0];
   assign fb       = b_q[FRAC_W-1:0];
   assign a_nan    = (&ea) && (|fa);
   assign b_nan    = (&eb) && (|fb);
   assign a_inf    = (&ea) && !(|fa);
   assign b_inf    = (&eb) && !(|fb);
   assign a_zero   = !(|ea);
   assign b_zero   = !(|eb);
   assign res_sign = a_q[W-1] ^ b_q[W-1];

   logic signed [EW-1:0] exp_mul, exp_div;
   assign exp_mul = $signed({2'b00, ea}) + $signed({2'b00, eb}) - BIAS;
   assign exp_div = $signed({2'b00, ea}) - $signed({2'b00, eb}) + BIAS;

   // Iteration datapath
   logic [MW:0]     mb_ext;
   logic [2*MW-1:0] addend;
   logic [MW+1:0]   diff;
   logic [MW:0]     rem_keep;

   assign mb_ext   = {1'b0, mb_q};
   // Multiplier bits are consumed MSB first; bit MW is a zero pad so the loop runs MW+1 times.
   assign addend   = mb_ext[cnt_q] ? {{MW{1'b0}}, ma_q} : '0;
   assign diff     = {1'b0, rem_q} - {2'b00, mb_q};
   assign rem_keep = diff[MW+1] ? rem_q : diff[MW:0];

   // Normalisation: product in [1,4), quotient in (0.5,2); at most one position of shift.
   logic signed [EW-1:0] exp_n;
   logic [FRAC_W-1:0]    frac_n;
   logic                 ovf_n, unf_n;

   always_comb begin
      exp_n  = exp_q;
      frac_n = '0;
      if (!op_q) begin
         if (prod_q[2*MW-1]) begin
            frac_n = prod_q[2*MW-2 -: FRAC_W];
            exp_n  = exp_q + ONE;
         end else begin
            frac_n = prod_q[2*MW-3 -: FRAC_W];
         end
      end else begin
         if (quo_q[MW]) begin
            frac_n = quo_q[MW-1:1];
         end else begin
            frac_n = quo_q[MW-2:0];
            exp_n  = exp_q - ONE;
         end
      end
      ovf_n = !exp_n[EW-1] && (exp_n >= EXP_MAX);
      unf_n = exp_n[EW-1] || (exp_n == '0);
   end

   // Low product bits and the remainder MSB fall below the truncation point.
   logic unused_bits;
   assign unused_bits = ^{prod_q[MW-2:0], rem_keep[MW]};

   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      a_d      = a_q;
      b_d      = b_q;
      sign_d   = sign_q;
      exp_d    = exp_q;
      ma_d     = ma_q;
      mb_d     = mb_q;
      cnt_d    = cnt_q;
      prod_d   = prod_q;
      rem_d    = rem_q;
      quo_d    = quo_q;
      result_d = result_q;
      flags_d  = flags_q;

      unique case (state_q)
         StIdle: begin
            if (in_valid) begin
               a_d     = a;
               b_d     = b;
               op_d    = op;
               state_d = StUnpack;
            end
         end

         StUnpack: begin
            sign_d  = res_sign;
            exp_d   = op_q ? exp_div : exp_mul;
            ma_d    = {1'b1, fa};
            mb_d    = {1'b1, fb};
            cnt_d   = CW'(MW);
            prod_d  = '0;
            rem_d   = {2'b01, fa};
            quo_d   = '0;
            state_d = StDone;
            if (a_nan || b_nan) begin
               result_d = QNAN;
               flags_d  = 4'b0000;
            end else if (!op_q && ((a_zero && b_inf) || (a_inf && b_zero))) begin
               result_d = QNAN;
               flags_d  = 4'b1000;
            end else if (!op_q && (a_inf || b_inf)) begin
               result_d = {res_sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
               flags_d  = 4'b0000;
            end else if (!op_q && (a_zero || b_zero)) begin
               result_d = {res_sign, {(W-1){1'b0}}};
               flags_d  = 4'b0000;
            end else if (op_q && ((a_zero && b_zero) || (a_inf && b_inf))) begin
               result_d = QNAN;
               flags_d  = 4'b1000;
            end else if (op_q && a_inf) begin
               result_d = {res_sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
               flags_d  = 4'b0000;
            end else if (op_q && b_zero) begin
               result_d = {res_sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
               flags_d  = 4'b0100;
            end else if (op_q && (a_zero || b_inf)) begin
               result_d = {res_sign, {(W-1){1'b0}}};
               flags_d  = 4'b0000;
            end else begin
               state_d = StIter;
            end
         end

         StIter: begin
            if (!op_q) begin
               prod_d = {prod_q[2*MW-2:0], 1'b0} + addend;
            end else begin
               quo_d = {quo_q[MW-1:0], !diff[MW+1]};
               rem_d = {rem_keep[MW-1:0], 1'b0};
            end
            if (cnt_q == '0) begin
               state_d = StNorm;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end

         StNorm: begin
            state_d = StDone;
            if (ovf_n) begin
               result_d = {sign_q, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
               flags_d  = 4'b0010;
            end else if (unf_n) begin
               result_d = {sign_q, {(W-1){1'b0}}};
               flags_d  = 4'b0001;
            end else begin
               result_d = {sign_q, exp_n[EXP_W-1:0], frac_n};
               flags_d  = 4'b0000;
            end
         end

         StDone: begin
            if (out_ready) begin
               state_d = StIdle;
            end
         end

         default: state_d = StIdle;
      endcase

      if (flush) begin
         state_d = StIdle;
      end

      out_valid_d = (state_d == StDone);
      in_ready_d  = (state_d == StIdle);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= StIdle;
         op_q        <= 1'b0;
         a_q         <= '0;
         b_q         <= '0;
         sign_q      <= 1'b0;
         exp_q       <= '0;
         ma_q        <= '0;
         mb_q        <= '0;
         cnt_q       <= '0;
         prod_q      <= '0;
         rem_q       <= '0;
         quo_q       <= '0;
         result_q    <= '0;
         flags_q     <= '0;
         out_valid_q <= 1'b0;
         in_ready_q  <= 1'b1;
      end else begin
         state_q     <= state_d;
         op_q        <= op_d;
         a_q         <= a_d;
         b_q         <= b_d;
         sign_q      <= sign_d;
         exp_q       <= exp_d;
         ma_q        <= ma_d;
         mb_q        <= mb_d;
         cnt_q       <= cnt_d;
         prod_q      <= prod_d;
         rem_q       <= rem_d;
         quo_q       <= quo_d;
         result_q    <= result_d;
         flags_q     <= flags_d;
         out_valid_q <= out_valid_d;
         in_ready_q  <= in_ready_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign result    = result_q;
   assign flags     = flags_q;

endmodule
